mem_access_ctrl: RTL

//  Sequences EX-stage loads/stores from the decoded load_op/store_op vectors onto a variable-latency

---
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences EX-stage loads/stores onto a req/ack data-memory port with strobes, lane replication and load extension.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  load_op,
  input  logic [2:0]  store_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  dest,
  output logic        busy,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        ale,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  lop_q, lop_d;
  logic [1:0]  lo_q, lo_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_wstrb_q, dm_wstrb_d;
  logic        wb_valid_q, wb_valid_d, done_q, done_d, ale_q, ale_d, err_q, err_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d, lane, ext;
  logic [7:0]  ops;
  logic        start, multi, mis;
  assign ops   = {load_op, store_op};
  assign start = state_q == IDLE && ex_valid && |ops;
  assign multi = |(ops & (ops - 8'd1));
  assign mis   = ((load_op[0] | store_op[0]) & |addr[1:0]) |
                 ((load_op[1] | load_op[3] | store_op[1]) & addr[0]);
  assign busy  = start || state_q == REQ || state_q == WAIT;
  assign lane  = dm_rdata >> {lo_q, 3'b000};
  assign ext   = lop_q[0] ? dm_rdata :
                 lop_q[1] ? {{16{lane[15]}}, lane[15:0]} :
                 lop_q[2] ? {{24{lane[7]}}, lane[7:0]} :
                 lop_q[3] ? {16'd0, lane[15:0]} : {24'd0, lane[7:0]};
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lop_d      = lop_q;
    lo_d       = lo_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wstrb_d = dm_wstrb_q;
    dm_wdata_d = dm_wdata_q;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    done_d     = 1'b0;
    ale_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (multi) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (mis) begin
          ale_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          state_d    = REQ;
          cnt_d      = 8'd0;
          lop_d      = load_op;
          lo_d       = addr[1:0];
          wb_dest_d  = dest;
          dm_req_d   = 1'b1;
          dm_we_d    = |store_op;
          dm_addr_d  = {addr[31:2], 2'b00};
          dm_wstrb_d = store_op[0] ? 4'b1111 :
                       store_op[1] ? (addr[1] ? 4'b1100 : 4'b0011) :
                       store_op[2] ? 4'b0001 << addr[1:0] : 4'b0000;
          dm_wdata_d = store_op[1] ? {2{wdata[15:0]}} :
                       store_op[2] ? {4{wdata[7:0]}} : wdata;
        end
      end
      REQ, WAIT: if (dm_ack) begin
        state_d    = DONE;
        dm_req_d   = 1'b0;
        done_d     = 1'b1;
        wb_valid_d = ~dm_we_q;
        wb_data_d  = dm_we_q ? wb_data_q : ext;
      end else if (state_q == REQ) begin
        state_d = WAIT;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        dm_req_d = 1'b0;
        err_d    = 1'b1;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lop_q      <= '0;
      lo_q       <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wstrb_q <= '0;
      dm_wdata_q <= '0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ale_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lop_q      <= lop_d;
      lo_q       <= lo_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wstrb_q <= dm_wstrb_d;
      dm_wdata_q <= dm_wdata_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      done_q     <= done_d;
      ale_q      <= ale_d;
      err_q      <= err_d;
    end
  end
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wstrb = dm_wstrb_q;
  assign dm_wdata = dm_wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_dest  = wb_dest_q;
  assign wb_data  = wb_data_q;
  assign done     = done_q;
  assign ale      = ale_q;
  assign err      = err_q;
endmodule
